// File: rtl/wtm_mult.sv
// 5x5 unsigned Wallace-tree multiplier: three 3:2/2:2 reduction layers feed a
// 10-bit ripple-carry adder; product and final carry are registered.

module wtm_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module wtm_ha (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b;
  assign cout = a & b;
endmodule

module wtm_mult (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] in1,
  input  logic [4:0] in2,
  output logic [9:0] out,
  output logic       cout
);
  logic [4:0] pp [5];

  for (genvar i = 0; i < 5; i++) begin : g_pp_i
    for (genvar j = 0; j < 5; j++) begin : g_pp_j
      assign pp[i][j] = in1[i] & in2[j];
    end
  end

  // Layer 1: column heights 1,2,3,4,5,4,3,2,1
  logic s1_1, c1_1, s1_2, c1_2, s1_3, c1_3, s1_4a, c1_4a, s1_4b, c1_4b;
  logic s1_5, c1_5, s1_6, c1_6, s1_7, c1_7;

  wtm_ha u_l1_1  (.a(pp[0][1]), .b(pp[1][0]),                 .sum(s1_1),  .cout(c1_1));
  wtm_fa u_l1_2  (.a(pp[0][2]), .b(pp[1][1]), .cin(pp[2][0]), .sum(s1_2),  .cout(c1_2));
  wtm_fa u_l1_3  (.a(pp[0][3]), .b(pp[1][2]), .cin(pp[2][1]), .sum(s1_3),  .cout(c1_3));
  wtm_fa u_l1_4a (.a(pp[0][4]), .b(pp[1][3]), .cin(pp[2][2]), .sum(s1_4a), .cout(c1_4a));
  wtm_ha u_l1_4b (.a(pp[3][1]), .b(pp[4][0]),                 .sum(s1_4b), .cout(c1_4b));
  wtm_fa u_l1_5  (.a(pp[1][4]), .b(pp[2][3]), .cin(pp[3][2]), .sum(s1_5),  .cout(c1_5));
  wtm_fa u_l1_6  (.a(pp[2][4]), .b(pp[3][3]), .cin(pp[4][2]), .sum(s1_6),  .cout(c1_6));
  wtm_ha u_l1_7  (.a(pp[3][4]), .b(pp[4][3]),                 .sum(s1_7),  .cout(c1_7));

  // Layer 2: heights 1,1,2,3,3,4,2,2,2
  logic s2_2, c2_2, s2_3, c2_3, s2_4, c2_4, s2_5, c2_5;
  logic s2_6, c2_6, s2_7, c2_7, s2_8, c2_8;

  wtm_ha u_l2_2 (.a(s1_2),     .b(c1_1),                 .sum(s2_2), .cout(c2_2));
  wtm_fa u_l2_3 (.a(s1_3),     .b(pp[3][0]), .cin(c1_2),  .sum(s2_3), .cout(c2_3));
  wtm_fa u_l2_4 (.a(s1_4a),    .b(s1_4b),    .cin(c1_3),  .sum(s2_4), .cout(c2_4));
  wtm_fa u_l2_5 (.a(s1_5),     .b(pp[4][1]), .cin(c1_4a), .sum(s2_5), .cout(c2_5));
  wtm_ha u_l2_6 (.a(s1_6),     .b(c1_5),                 .sum(s2_6), .cout(c2_6));
  wtm_ha u_l2_7 (.a(s1_7),     .b(c1_6),                 .sum(s2_7), .cout(c2_7));
  wtm_ha u_l2_8 (.a(pp[4][4]), .b(c1_7),                 .sum(s2_8), .cout(c2_8));

  // Layer 3: heights 1,1,1,2,2,3,2,2,2,1 -> at most two per column afterwards
  logic s3_3, c3_3, s3_4, c3_4, s3_5, c3_5, s3_6, c3_6, s3_7, c3_7, s3_8, c3_8;

  wtm_ha u_l3_3 (.a(s2_3), .b(c2_2),               .sum(s3_3), .cout(c3_3));
  wtm_ha u_l3_4 (.a(s2_4), .b(c2_3),               .sum(s3_4), .cout(c3_4));
  wtm_fa u_l3_5 (.a(s2_5), .b(c1_4b), .cin(c2_4),  .sum(s3_5), .cout(c3_5));
  wtm_ha u_l3_6 (.a(s2_6), .b(c2_5),               .sum(s3_6), .cout(c3_6));
  wtm_ha u_l3_7 (.a(s2_7), .b(c2_6),               .sum(s3_7), .cout(c3_7));
  wtm_ha u_l3_8 (.a(s2_8), .b(c2_7),               .sum(s3_8), .cout(c3_8));

  logic [9:0] row_a, row_b, sum_d;
  logic [10:0] carry;

  assign row_a = {c2_8, s3_8, s3_7, s3_6, s3_5, s3_4, s3_3, s2_2, s1_1, pp[0][0]};
  assign row_b = {c3_8, c3_7, c3_6, c3_5, c3_4, c3_3, 4'b0000};

  assign carry[0] = 1'b0;
  wtm_ha u_rca_0 (.a(row_a[0]), .b(row_b[0]), .sum(sum_d[0]), .cout(carry[1]));
  for (genvar k = 1; k < 10; k++) begin : g_rca
    wtm_fa u_rca (.a(row_a[k]), .b(row_b[k]), .cin(carry[k]), .sum(sum_d[k]), .cout(carry[k+1]));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out  <= 10'd0;
      cout <= 1'b0;
    end else begin
      out  <= sum_d;
      cout <= carry[10];
    end
  end
endmodule

// File: tb/tb_wtm_mult.sv
// Scoreboard bench for wtm_mult: driver pushes expected products, a monitor
// pops and compares one cycle after each applied operand pair.

module tb_wtm_mult;
  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] in1, in2;
  logic [9:0] out;
  logic       cout;

  typedef struct {
    logic       rst;
    logic [4:0] a;
    logic [4:0] b;
    logic [9:0] prod;
    logic       co;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  wtm_mult dut (
    .clock(clock),
    .reset(reset),
    .in1  (in1),
    .in2  (in2),
    .out  (out),
    .cout (cout)
  );

  always #5 clock = ~clock;

  task automatic apply(input logic r, input logic [4:0] a, input logic [4:0] b);
    exp_t e;
    int   p;
    @(negedge clock);
    reset = r;
    in1   = a;
    in2   = b;
    p     = int'(a) * int'(b);
    e.rst  = r;
    e.a    = a;
    e.b    = b;
    e.prod = r ? 10'd0 : p[9:0];
    e.co   = 1'b0;
    q.push_back(e);
  endtask

  // Monitor: each rising edge consumes the pair applied just before it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if (out !== e.prod || cout !== e.co) begin
          fails++;
          $display("FAIL prod rst=%0b %0d*%0d: got out=%0d cout=%0b, expected out=%0d cout=%0b",
                   e.rst, e.a, e.b, out, cout, e.prod, e.co);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    in1   = '0;
    in2   = '0;

    apply(1'b1, 5'd7, 5'd9);
    apply(1'b0, 5'd7, 5'd9);
    apply(1'b0, 5'd0, 5'd20);
    apply(1'b0, 5'd25, 5'd16);
    apply(1'b0, 5'd31, 5'd1);
    apply(1'b0, 5'd31, 5'd31);
    apply(1'b0, 5'd1, 5'd19);
    apply(1'b0, 5'd0, 5'd20);
    apply(1'b1, 5'd25, 5'd16);
    apply(1'b0, 5'd31, 5'd1);

    for (int a = 0; a < 32; a++)
      for (int b = 0; b < 32; b++)
        apply(1'b0, 5'(a), 5'(b));

    for (int n = 0; n < 300; n++)
      apply(($urandom_range(0, 19) == 0), 5'($urandom), 5'($urandom));

    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left in scoreboard, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
